mu0_prog_loader: RTL and testbench

- Writer side of the MU0 program memory that the CPU decoder's FETCH/EXEC sequence reads.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs big-endian into 16-bit instruction words ({OP[15:12], operand[11:0]}).
- Writes each word to program RAM at consecutive addresses from 0.
- Holds the CPU in reset during loading and releases it when the final word has been written.

---
 rtl/mu0_prog_loader_if.sv | 32 +++
 rtl/mu0_prog_loader.sv | 127 ++++++++++++
 tb/tb_mu0_prog_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mu0_prog_loader_if.sv
// Byte-stream input, program-RAM write port and status outputs of the MU0 program loader.
// The loader uses the slave modport; the producer/observer side uses master.
interface mu0_prog_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_last;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    modport slave (
        input  start, rx_data, rx_valid, rx_last,
        output rx_ready, mem_addr, mem_data, mem_wren,
        output cpu_hold, busy, done, err, word_count
    );

    modport master (
        output start, rx_data, rx_valid, rx_last,
        input  rx_ready, mem_addr, mem_data, mem_wren,
        input  cpu_hold, busy, done, err, word_count
    );
endinterface

// File: rtl/mu0_prog_loader.sv
// Purpose: packs a big-endian byte stream into 16-bit MU0 words, writes them to program RAM from 0, holds CPU in reset until done.
// Latency: write strobe on the cycle after the low byte is accepted; peak 1 word per 3 cycles.
// Backpressure: rx_ready only in HI/LO states, dropped during WRITE and when idle. Optional MU0_LOADER_OPCHECK_EN rejects opcodes 0xB-0xF.
module mu0_prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mu0_prog_loader_if.slave   bus
);
    localparam int BYTE_W = DATA_W / 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_inc;
    logic              rx_rdy;
    logic              xfer;
    logic              op_ok;
    logic              wr_en;

    assign rx_rdy    = (state_q == S_HI) || (state_q == S_LO);
    assign xfer      = rx_rdy && bus.rx_valid;
    assign count_inc = count_q + CNT_ONE;

`ifdef MU0_LOADER_OPCHECK_EN
    // Opcodes above LSR (0xA) are undefined on MU0; refuse to write them.
    assign op_ok = (hi_q[7:4] <= 4'hA);
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        last_d  = last_q;
        addr_d  = addr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_HI;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d = bus.rx_data;
                    // A last marker on a high byte means an odd-length program.
                    state_d = bus.rx_last ? S_ERR : S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = bus.rx_data;
                    last_d  = bus.rx_last;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!op_ok) begin
                    state_d = S_ERR;
                end else begin
                    wr_en   = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_inc;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (count_inc == CNT_FULL) begin
                        // Memory full without a stop marker; address wraps but is never written.
                        state_d = S_ERR;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign bus.rx_ready   = rx_rdy;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = {hi_q, lo_q};
    assign bus.mem_wren   = wr_en;
    assign bus.cpu_hold   = (state_q != S_DONE);
    assign bus.busy       = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WRITE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_mu0_prog_loader.sv
// Directed bench for mu0_prog_loader with a 4-bit address space so the overflow path is reachable.
module tb_mu0_prog_loader;
    logic clk;
    logic rst_n;

    mu0_prog_loader_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    mu0_prog_loader #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ready_viol = 0;
    int xfer_cnt   = 0;
    logic [3:0]  wa[$];
    logic [15:0] wd[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe write strobes and byte transfers mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_data);
            if (bus.rx_ready !== 1'b0) ready_viol++;
        end
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) xfer_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int t;
        t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.rx_last  = l;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk("rx_ready_timeout", 32'(t < 20), 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        ready_viol = 0;
    endtask

    initial begin
        int xc;
        bus.start    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
        rst_n = 1'b0;

        // Reset values
        #3;
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_ready", 32'(bus.rx_ready), 32'd0);

        // Two-word program, back-to-back bytes
        clear_log();
        pulse_start();
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_ready", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h80, 1'b0, 0);
        pulse_start();
        chk("t1_start_ignored_lo", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h05, 1'b0, 0);
        chk("t1_wren_latency", 32'(bus.mem_wren), 32'd1);
        chk("t1_wr_data_now", 32'(bus.mem_data), 32'h8005);
        send_byte(8'h70, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("t1_nwrites", 32'(wa.size()), 32'd2);
        chk("t1_a0", 32'(wa[0]), 32'd0);
        chk("t1_d0", 32'(wd[0]), 32'h8005);
        chk("t1_a1", 32'(wa[1]), 32'd1);
        chk("t1_d1", 32'(wd[1]), 32'h7000);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t1_word_count", 32'(bus.word_count), 32'd2);
        chk("t1_ready_in_write", 32'(ready_viol), 32'd0);

        // Same program with rx_valid gapped every other cycle
        clear_log();
        pulse_start();
        chk("t2_done_cleared", 32'(bus.done), 32'd0);
        chk("t2_count_cleared", 32'(bus.word_count), 32'd0);
        chk("t2_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t2_addr_cleared", 32'(bus.mem_addr), 32'd0);
        xc = xfer_cnt;
        send_byte(8'h80, 1'b0, 1);
        send_byte(8'h05, 1'b0, 1);
        send_byte(8'h70, 1'b0, 1);
        send_byte(8'h00, 1'b1, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_xfers", 32'(xfer_cnt - xc), 32'd4);
        chk("t2_nwrites", 32'(wa.size()), 32'd2);
        chk("t2_d0", 32'(wd[0]), 32'h8005);
        chk("t2_d1", 32'(wd[1]), 32'h7000);
        chk("t2_a1", 32'(wa[1]), 32'd1);
        chk("t2_ready_in_write", 32'(ready_viol), 32'd0);
        chk("t2_done", 32'(bus.done), 32'd1);

        // Odd byte count
        clear_log();
        pulse_start();
        send_byte(8'h10, 1'b0, 0);
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h30, 1'b1, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t3_nwrites", 32'(wa.size()), 32'd1);
        chk("t3_d0", 32'(wd[0]), 32'h1020);
        chk("t3_a0", 32'(wa[0]), 32'd0);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_done", 32'(bus.done), 32'd0);
        chk("t3_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t3_word_count", 32'(bus.word_count), 32'd1);

        // Fill all 16 addresses without a last marker
        clear_log();
        pulse_start();
        chk("t4_err_cleared", 32'(bus.err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0, 0);
            send_byte(8'(8'hA0 + i), 1'b0, 0);
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("t4_nwrites", 32'(wa.size()), 32'd16);
        chk("t4_first", {12'd0, wa[0], wd[0]}, 32'h0_00A0);
        chk("t4_last", {12'd0, wa[15], wd[15]}, 32'hF_0FAF);
        chk("t4_err", 32'(bus.err), 32'd1);
        chk("t4_word_count", 32'(bus.word_count), 32'd16);
        chk("t4_addr_wrapped", 32'(bus.mem_addr), 32'd0);
        xc = xfer_cnt;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        repeat (3) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b0;
        chk("t4_no_17th", 32'(xfer_cnt - xc), 32'd0);
        chk("t4_nwrites_after", 32'(wa.size()), 32'd16);

        // Opcode 0xF in the second word
        clear_log();
        pulse_start();
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t5_d0", {12'd0, wa[0], wd[0]}, 32'h0_2001);
`ifdef MU0_LOADER_OPCHECK_EN
        chk("t5_nwrites", 32'(wa.size()), 32'd1);
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_word_count", 32'(bus.word_count), 32'd1);
`else
        chk("t5_nwrites", 32'(wa.size()), 32'd2);
        chk("t5_d1", {12'd0, wa[1], wd[1]}, 32'h1_F000);
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_word_count", 32'(bus.word_count), 32'd2);
`endif

        // Async reset while waiting for a low byte
        clear_log();
        pulse_start();
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        send_byte(8'h77, 1'b0, 0);
        chk("t6_in_lo", 32'(bus.rx_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t6_ready", 32'(bus.rx_ready), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_word_count", 32'(bus.word_count), 32'd0);
        chk("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_mem_data", 32'(bus.mem_data), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        pulse_start();
        send_byte(8'hAB, 1'b0, 0);
        send_byte(8'hCD, 1'b1, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_reload", {12'd0, wa[0], wd[0]}, 32'h0_ABCD);
        chk("t6_nwrites", 32'(wa.size()), 32'd1);
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_final_count", 32'(bus.word_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
